// File: rtl/toy_membus_arbiter.sv
// toy_membus_arbiter: shares one single-word memory bus between the icache fill port and the CPU data port
//
// Ports:
//   clk, reset           system clock; synchronous active-low reset
//   i_rd, i_addr         icache read request (level, held until i_ready) and word address
//   i_data, i_ready      icache read data and its one-cycle completion pulse
//   d_rd, d_wr           data-port read / write requests (level; write wins when both set)
//   d_addr, d_wdata      data-port word address and write data
//   d_rdata, d_ready     data-port read data (0 for writes) and its one-cycle completion pulse
//   mem_addr, mem_wdata  registered memory address and write data
//   mem_rd, mem_wr       registered memory strobes, held until mem_ready
//   mem_rdata, mem_ready memory read data and one-cycle completion pulse
//
// Build option: define TOY_MEMARB_RR_EN for round-robin arbitration of simultaneous
// requests; otherwise the data port always wins a tie.
module toy_membus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_rd,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_data,
    output logic          i_ready,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_DONE} state_t;
    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic [DW-1:0] i_data_q, i_data_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_req;
    logic          d_wins;
    assign d_req = d_rd | d_wr;
`ifdef TOY_MEMARB_RR_EN
    // On a tie the port that was not granted last time goes first.
    assign d_wins = d_req & (~i_rd | ~last_q);
`else
    assign d_wins = d_req;
`endif
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_data_d    = i_data_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (d_wins) begin
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wr_d    = d_wr;
                    mem_rd_d    = ~d_wr;
                    last_d      = 1'b1;
                    state_d     = S_BUSY_D;
                end else if (i_rd) begin
                    mem_addr_d = i_addr;
                    mem_rd_d   = 1'b1;
                    last_d     = 1'b0;
                    state_d    = S_BUSY_I;
                end
            end
            S_BUSY_I: begin
                if (mem_ready) begin
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    i_ready_d = 1'b1;
                    i_data_d  = mem_rdata;
                    state_d   = S_DONE;
                end
            end
            S_BUSY_D: begin
                if (mem_ready) begin
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = mem_wr_q ? '0 : mem_rdata;
                    state_d   = S_DONE;
                end
            end
            // Recovery cycle: a requester still holding its old request is not re-granted.
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_data_q    <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_data_q    <= i_data_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_toy_membus_arbiter.sv
// tb_toy_membus_arbiter: directed and randomized transactions checked against a transaction-level arbitration model
module tb_toy_membus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_rd, d_rd, d_wr, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_data, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, mem_rd, mem_wr;
    int          errors = 0;
    int          checks = 0;
    int          rises = 0;
    logic        rd_prev = 1'b0;
    bit          m_last;
    logic        obs_d;
    logic [3:0]  grants;
    int          base;

    toy_membus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_rd && !rd_prev) rises <= rises + 1;
        rd_prev <= mem_rd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Which port wins given the current requests and the last granted port (1 = D).
    function automatic bit exp_d(bit ireq, bit dreq, bit last);
        if (!dreq) return 1'b0;
        if (!ireq) return 1'b1;
`ifdef TOY_MEMARB_RR_EN
        return !last;
`else
        return 1'b1;
`endif
    endfunction

    // Runs one transaction; requests must already be driven and the arbiter idle at the next edge.
    task automatic txn(input int lat, input logic [31:0] rv, input bit scramble);
        bit          ed, ew;
        logic [31:0] ea, ewd;
        ed  = exp_d(i_rd, d_rd | d_wr, m_last);
        ew  = ed & d_wr;
        ea  = ed ? d_addr : i_addr;
        ewd = d_wdata;
        @(posedge clk); #1;
        chk("mem_rd", mem_rd, !ew);
        chk("mem_wr", mem_wr, ew);
        chk("mem_addr", mem_addr, ea);
        if (ed) chk("mem_wdata", mem_wdata, ewd);
        m_last = ed;
        if (scramble) begin
            i_rd = 1'($urandom); d_rd = 1'($urandom); d_wr = 1'($urandom);
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        end
        repeat (lat) begin
            @(posedge clk); #1;
            chk("strobe_hold", mem_rd | mem_wr, 1);
            chk("early_ready", i_ready | d_ready, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = rv;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        chk("i_ready", i_ready, !ed);
        chk("d_ready", d_ready, ed);
        if (ed) chk("d_rdata", d_rdata, ew ? 32'h0 : rv);
        else chk("i_data", i_data, rv);
        chk("strobe_drop", {mem_rd, mem_wr}, 0);
        obs_d = d_ready;
        @(posedge clk); #1;
        chk("ready_clear", {i_ready, d_ready}, 0);
        chk("no_reissue", {mem_rd, mem_wr}, 0);
        if (ed) chk("d_rdata_hold", d_rdata, ew ? 32'h0 : rv);
        else chk("i_data_hold", i_data, rv);
    endtask

    initial begin
        reset = 1'b0; i_rd = 0; d_rd = 0; d_wr = 0; mem_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_data", i_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;
        m_last = 1'b1;
        i_rd = 1; i_addr = 32'h100;
        txn(2, 32'hDEADBEEF, 0);
        i_rd = 0;
        d_wr = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
        txn(1, $urandom, 0);
        d_wr = 0;
        @(posedge clk); #1;
        chk("no_i_after_write", {i_ready, mem_rd}, 0);
        i_rd = 1; i_addr = 32'h104;
        txn(0, $urandom, 0);
        d_rd = 1; d_addr = 32'h208;
        for (int k = 0; k < 4; k++) begin
            txn($urandom_range(0, 2), $urandom, 0);
            grants[3-k] = obs_d;
        end
`ifdef TOY_MEMARB_RR_EN
        chk("grant_seq", grants, 4'b1010);
`else
        chk("grant_seq", grants, 4'b1111);
`endif
        i_rd = 0; d_rd = 0;
        d_rd = 1; d_wr = 1; d_addr = 32'h300; d_wdata = 32'hA5A5A5A5;
        txn(1, 32'hFFFFFFFF, 0);
        d_rd = 0; d_wr = 0;
        @(posedge clk); #1;
        base = rises;
        for (int w = 0; w < 16; w++) begin
            i_rd = 1; i_addr = 32'h40 + w;
            txn($urandom_range(0, 3), $urandom, 0);
            i_rd = 0;
            @(posedge clk); #1;
            chk("fill_gap", mem_rd, 0);
        end
        chk("fill_reads", rises - base, 16);
        d_rd = 1; d_addr = 32'h500;
        @(posedge clk); #1;
        chk("pre_abort_rd", mem_rd, 1);
        d_rd = 0; reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_strobes", {mem_rd, mem_wr}, 0);
        chk("abort_ready", {i_ready, d_ready}, 0);
        reset = 1'b1; m_last = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("stray_ready", {i_ready, d_ready}, 0);
        chk("stray_strobes", {mem_rd, mem_wr}, 0);
        i_rd = 1; i_addr = 32'h600; d_rd = 1; d_addr = 32'h604;
        txn(0, $urandom, 0);
        i_rd = 0; d_rd = 0;
        for (int n = 0; n < 40; n++) begin
            int r;
            if ($urandom_range(0, 3) == 0) begin
                i_rd = 0; d_rd = 0; d_wr = 0; mem_ready = 1'($urandom);
                @(posedge clk); #1;
                mem_ready = 1'b0;
                chk("idle_quiet", {i_ready, d_ready, mem_rd, mem_wr}, 0);
            end
            r = $urandom_range(1, 7);
            i_rd = r[0]; d_rd = r[1]; d_wr = r[2];
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            txn($urandom_range(0, 3), $urandom, 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
